// File: rtl/mem_line_responder.sv
// Memory-side line responder: accepts one line request, waits WAIT_CYCLES, then moves one word per MRdy cycle; MDone follows the last word.
// No backpressure: the cache must source/sink a word on every MRdy cycle. MEM_CRIT_WORD_FIRST_EN selects critical-word-first ordering.
module mem_line_responder #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int WAIT_CYCLES    = 3
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              MStrobe,
    input  logic                              MRW,
    input  logic [ADDR_W-1:0]                 MAddr,
    input  logic [DATA_W-1:0]                 MDataIn,
    output logic [DATA_W-1:0]                 MDataOut,
    output logic [$clog2(WORDS_PER_LINE)-1:0] MWord,
    output logic                              MRdy,
    output logic                              MDone,
    output logic                              Busy
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int WC_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int CNT_W = (WC_W > OFF_W) ? WC_W : OFF_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;
    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

    function automatic mem_t mem_init();
        mem_t m;
        for (int k = 0; k < DEPTH; k++) begin
            m[k] = DATA_W'(k);
        end
        return m;
    endfunction

    // Power-up contents are array[k] = k; reset never touches the array.
    mem_t mem_q = mem_init();

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  word_q, word_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [OFF_W-1:0]  start_off;
    logic [OFF_W-1:0]  word_nxt;
    logic [ADDR_W-1:0] word_addr;
    logic              mem_we;

    always_comb begin
`ifdef MEM_CRIT_WORD_FIRST_EN
        start_off = MAddr[OFF_W-1:0];
`else
        start_off = '0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        base_d    = base_q;
        word_d    = word_q;
        dout_d    = dout_q;
        mem_we    = 1'b0;
        word_nxt  = word_q + OFF_W'(1);
        word_addr = base_q | ADDR_W'(word_q);

        case (state_q)
            S_IDLE: begin
                if (MStrobe) begin
                    rw_d    = MRW;
                    base_d  = MAddr & ~ADDR_W'(WORDS_PER_LINE - 1);
                    word_d  = start_off;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Prefetch the first word so it is registered in the first MRdy cycle.
                    dout_d  = mem_q[word_addr];
                    cnt_d   = CNT_W'(WORDS_PER_LINE - 1);
                    state_d = S_XFER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_XFER: begin
                mem_we = ~rw_q;
                word_d = word_nxt;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    dout_d = mem_q[base_q | ADDR_W'(word_nxt)];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rdy_d  = (state_d == S_XFER);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            base_q  <= '0;
            word_q  <= '0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            base_q  <= base_d;
            word_q  <= word_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // A write word landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem_q[word_addr] <= MDataIn;
        end
    end

    assign MDataOut = dout_q;
    assign MWord    = word_q;
    assign MRdy     = rdy_q;
    assign MDone    = done_q;
    assign Busy     = busy_q;

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Main-memory side of the cache-to-memory protocol. It accepts a line request (MStrobe/MRW/MAddr) from the cache controller, inserts a fixed access latency, then streams one cache line word-by-word. Each word is either returned to the cache (read/fill) or taken from the cache (write-back), and completion is signalled with a one-cycle MDone. It sits between the cache controller FSM and the backing word array, which it contains.

## Interface
- ADDR_W, 8, word address width; array depth is 2**ADDR_W words
- DATA_W, 32, word width
- WORDS_PER_LINE, 4, words per line; power of two, ≥2
- WAIT_CYCLES, 3, access latency in cycles before the first word; ≥1

- clk  in  1  clock; all state changes on its rising edge
- reset_n  in  1  reset, synchronous, active-low
- MStrobe  in  1  request strobe from the cache; sampled only in IDLE
- MRW  in  1  1 = read (line fill), 0 = write (write-back)
- MAddr  in  ADDR_W  word address of the request
- MDataIn  in  DATA_W  write data from the cache, valid when MRdy=1 and the request is a write
- MDataOut  out  DATA_W  read data, valid when MRdy=1 and the request is a read
- MWord  out  log2(WORDS_PER_LINE)  line offset of the current word; valid when MRdy=1
- MRdy  out  1  word-transfer strobe, one cycle per word
- MDone  out  1  one-cycle pulse after the last word of a line
- Busy  out  1  high from acceptance through the MDone cycle

## Operation
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - If MStrobe=1, latch MRW, the line base (MAddr with the low log2(WORDS_PER_LINE) bits cleared) and the start offset, then go to WAIT.
  - The start offset is 0, or the low bits of MAddr (see Configuration).
  - Otherwise stay in IDLE.
- WAIT:
  - Load a down-counter with WAIT_CYCLES−1 on entry and decrement it each cycle.
  - Go to XFER when it reaches 0, so WAIT lasts exactly WAIT_CYCLES cycles.
- XFER:
  - Runs for exactly WORDS_PER_LINE cycles with MRdy=1 every cycle.
  - Word order: offset = (start + i) mod WORDS_PER_LINE, i = 0..WORDS_PER_LINE−1. MWord = offset.
  - Read: MDataOut = array[base + offset], driven from a registered output in the same cycle MRdy is high.
  - Write: array[base + offset] ← MDataIn at the rising edge that ends the MRdy cycle.
  - After the last word, go to DONE.
- DONE: MDone=1 for one cycle, then go to IDLE.
- Outside IDLE, MStrobe, MRW and MAddr are ignored. The latched copies are used for the whole transaction.
- Address arithmetic: base + offset never carries out of the line, because base is aligned. The array index is ADDR_W bits and wraps naturally.
- In simulation, the array is initialised so array[k] = k, zero-extended to DATA_W. Reset does not alter array contents.

## Timing
- Reset (reset_n=0 at an edge):
  - Next state is IDLE.
  - MRdy=0, MDone=0, Busy=0, MDataOut=0, MWord=0.
  - Counters and latched request are cleared.
  - Reset has priority over everything, including a write word at the same edge: that word is not written.
- Reset mid-transaction: the transaction is abandoned and there is no MDone. Words written at earlier edges remain in the array.
- MStrobe sampled high in IDLE at edge T:
  - Busy=1 from T.
  - First MRdy in the cycle starting at edge T+WAIT_CYCLES.
  - Last MRdy at T+WAIT_CYCLES+WORDS_PER_LINE−1.
  - MDone at T+WAIT_CYCLES+WORDS_PER_LINE.
  - Busy falls at the next edge.
- Total occupancy is WAIT_CYCLES+WORDS_PER_LINE+1 cycles. This is identical for reads and writes.
- Back-to-back: MStrobe high during DONE is ignored. MStrobe high in the first IDLE cycle after DONE is accepted, giving a minimum gap of one IDLE cycle.
- MRdy, MDone and Busy are registered outputs with no combinational path from inputs.

## Configuration
- MEM_CRIT_WORD_FIRST_EN
  - Defined: the start offset is MAddr[log2(WORDS_PER_LINE)−1:0] (critical word first), wrapping modulo WORDS_PER_LINE.
  - Undefined: the start offset is always 0 (ascending from the line base), and the low MAddr bits are ignored.
- Latency and occupancy are unchanged in both builds.

## Test plan
- Read, defaults, MAddr=0x12, no macro -> MRdy at cycles T+3..T+6; MWord 0,1,2,3; MDataOut 0x10,0x11,0x12,0x13; MDone at T+7; Busy low at T+8.
- Write, MAddr=0x20, MDataIn 0xA0..0xA3 on the four MRdy cycles, then read 0x20 -> read returns 0xA0,0xA1,0xA2,0xA3.
- With MEM_CRIT_WORD_FIRST_EN, read MAddr=0x13 -> MWord 3,0,1,2 and MDataOut 0x13,0x10,0x11,0x12; timing is unchanged.
- MStrobe held high continuously with MAddr changed to 0x40 during WAIT -> the first line still uses 0x10; a second request for 0x40 is accepted one cycle after MDone.
- reset_n=0 during the second word of a write to 0x30 -> outputs are 0 at the next edge and there is no MDone. The subsequent read of 0x30 returns the new word 0 and the original values 0x31,0x32,0x33.
- WAIT_CYCLES=1, WORDS_PER_LINE=2 -> first MRdy at T+1, MDone at T+3.
